pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. Merges the data-cache stall request, the load-use hazard and the branch-taken flush into one prioritised set of per-stage controls for PC, IF_ID and ID_EX. A branch flush that arrives while the memory stall freezes the pipeline is latched and replayed on resume. A watchdog flags memory stalls that run too long.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/sat_counter.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and default parameters for the pipeline
//               stall/flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_MEM_STALL = 2'd2,
        ST_RESUME    = 2'd3
    } state_t;

    localparam int DEF_STALL_TIMEOUT = 1024;
    localparam int DEF_CNT_W         = 32;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that holds at MAX.
//               Used for the stall watchdog and the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Clear has priority over increment; increment stops at MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush sequencer for the five-stage pipeline.
//               Merges memory stall, load-use hazard and branch flush into
//               prioritised PC / IF_ID / ID_EX controls, replays a branch
//               flush that arrived during a freeze, and flags overlong
//               memory stalls.
//               Optional macro STALL_PERF_CNT_EN adds performance counters;
//               without it the counter outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             mem_stall_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    output logic             cpu_stall_o,
    output logic             pc_write_o,
    output logic             if_id_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             stall_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o,
    output logic [CNT_W-1:0] load_use_count_o
);

    localparam int              WD_W    = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(STALL_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TIMEOUT - 1);

    state_t          state;
    logic            pend_flush;
    logic            wd_inc;
    logic [WD_W-1:0] wd_count;

    // Combinational controls: the freeze has no lag on miss entry; a flush
    // (live or replayed) beats a load-use hold.
    always_comb begin
        cpu_stall_o    = mem_stall_i | ~start_i;
        if_id_flush_o  = ~cpu_stall_o & (branch_taken_i | pend_flush);
        if_id_hold_o   = cpu_stall_o | (load_use_i & ~if_id_flush_o);
        pc_write_o     = ~if_id_hold_o;
        id_ex_bubble_o = ~cpu_stall_o & (load_use_i | if_id_flush_o);
    end

    // Sequencer state; dropping start_i returns to IDLE from anywhere
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else if (!start_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      state <= ST_RUN;
                ST_RUN:       state <= mem_stall_i ? ST_MEM_STALL : ST_RUN;
                ST_MEM_STALL: state <= mem_stall_i ? ST_MEM_STALL : ST_RESUME;
                ST_RESUME:    state <= mem_stall_i ? ST_MEM_STALL : ST_RUN;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    // Remember a branch flush seen while frozen; consumed by the first
    // unfrozen cycle. Set and clear are mutually exclusive because the
    // flush output is only active when not stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_flush <= 1'b0;
        end else begin
            pend_flush <= (branch_taken_i & cpu_stall_o) | (pend_flush & ~if_id_flush_o);
        end
    end

    // A cycle counts towards the watchdog when the running pipeline is
    // held by a data-cache miss; any other cycle restarts the count.
    assign wd_inc = mem_stall_i & start_i & (state != ST_IDLE);

    sat_counter #(
        .WIDTH (WD_W),
        .MAX   (WD_MAX)
    ) u_watchdog (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .inc   (wd_inc),
        .clr   (~wd_inc),
        .count (wd_count)
    );

    // Sticky timeout flag, raised on the edge where the count reaches the limit
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_timeout_o <= 1'b0;
        end else if (wd_inc && (wd_count >= WD_LAST)) begin
            stall_timeout_o <= 1'b1;
        end
    end

`ifdef STALL_PERF_CNT_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .inc   (mem_stall_i),
        .clr   (1'b0),
        .count (stall_cycles_o)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .inc   (if_id_flush_o),
        .clr   (1'b0),
        .count (flush_count_o)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_load_use_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .inc   (load_use_i & ~cpu_stall_o & ~if_id_flush_o),
        .clr   (1'b0),
        .count (load_use_count_o)
    );
`else
    assign stall_cycles_o   = '0;
    assign flush_count_o    = '0;
    assign load_use_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl: table of
//               single-cycle control vectors plus hand-written stall,
//               replay, watchdog and asynchronous-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             mem_stall;
    logic             load_use;
    logic             branch_taken;
    logic             cpu_stall;
    logic             pc_write;
    logic             if_id_hold;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] load_use_count;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(
        .STALL_TIMEOUT (8),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .start_i          (start),
        .mem_stall_i      (mem_stall),
        .load_use_i       (load_use),
        .branch_taken_i   (branch_taken),
        .cpu_stall_o      (cpu_stall),
        .pc_write_o       (pc_write),
        .if_id_hold_o     (if_id_hold),
        .if_id_flush_o    (if_id_flush),
        .id_ex_bubble_o   (id_ex_bubble),
        .stall_timeout_o  (stall_timeout),
        .stall_cycles_o   (stall_cycles),
        .flush_count_o    (flush_count),
        .load_use_count_o (load_use_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs plus expected {cpu_stall, pc_write, if_id_hold, if_id_flush, id_ex_bubble}
    typedef struct packed {
        logic       start;
        logic       mem;
        logic       lu;
        logic       br;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ctl_chk(input string name, input logic [4:0] exp);
        chk(name, {27'd0, cpu_stall, pc_write, if_id_hold, if_id_flush, id_ex_bubble}, {27'd0, exp});
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        start        = 1'b0;
        mem_stall    = 1'b0;
        load_use     = 1'b0;
        branch_taken = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b01000};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b00101};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b01011};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'b01011};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10100};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10100};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b01000};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b10100};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b01000};

        // ---- Reset state and plain run ----
        do_reset();
        rst_n = 1'b0;
        #3;
        ctl_chk("reset_ctl", 5'b10100);
        chk("reset_timeout", {31'd0, stall_timeout}, 32'd0);
        chk("reset_stall_cnt", stall_cycles, 32'd0);
        chk("reset_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        cyc();
        rst_n = 1'b1;
        start = 1'b1;
        #3;
        ctl_chk("run_first", 5'b01000);
        cyc();
        chk("run_state", {30'd0, dut.state}, {30'd0, ST_RUN});
        for (int i = 0; i < 3; i++) begin
            #3;
            ctl_chk($sformatf("run_cyc%0d", i), 5'b01000);
            cyc();
        end

        // ---- Table of single-cycle vectors ----
        for (int i = 0; i < 9; i++) begin
            start        = vecs[i].start;
            mem_stall    = vecs[i].mem;
            load_use     = vecs[i].lu;
            branch_taken = vecs[i].br;
            #3;
            ctl_chk($sformatf("vec%0d", i), vecs[i].exp);
            cyc();
        end
        load_use = 1'b0;
        #3;
`ifdef STALL_PERF_CNT_EN
        chk("tbl_load_use_cnt", load_use_count, 32'd1);
        chk("tbl_flush_cnt", flush_count, 32'd2);
        chk("tbl_stall_cnt", stall_cycles, 32'd2);
`else
        chk("tbl_load_use_cnt", load_use_count, 32'd0);
        chk("tbl_flush_cnt", flush_count, 32'd0);
        chk("tbl_stall_cnt", stall_cycles, 32'd0);
`endif

        // ---- 5-cycle stall with branch in stall cycle 2, replay on resume ----
        do_reset();
        start = 1'b1;
        cyc();
        cyc();
        for (int k = 1; k <= 5; k++) begin
            mem_stall    = 1'b1;
            branch_taken = (k == 2);
            #3;
            ctl_chk($sformatf("stall_cyc%0d", k), 5'b10100);
            cyc();
        end
        mem_stall    = 1'b0;
        branch_taken = 1'b0;
        #3;
        ctl_chk("replay_flush", 5'b01011);
        cyc();
        #3;
        ctl_chk("after_replay", 5'b01000);
        chk("pend_cleared", {31'd0, dut.pend_flush}, 32'd0);
        chk("no_timeout_short", {31'd0, stall_timeout}, 32'd0);
`ifdef STALL_PERF_CNT_EN
        chk("stall_cnt5", stall_cycles, 32'd5);
        chk("flush_cnt1", flush_count, 32'd1);
`else
        chk("stall_cnt5", stall_cycles, 32'd0);
        chk("flush_cnt1", flush_count, 32'd0);
`endif

        // ---- Watchdog: timeout 8, stall held 10 cycles ----
        do_reset();
        start = 1'b1;
        cyc();
        cyc();
        for (int k = 1; k <= 10; k++) begin
            mem_stall = 1'b1;
            #3;
            // k-1 stall edges have elapsed at this point
            if (k == 8) chk("wd_before_8th", {31'd0, stall_timeout}, 32'd0);
            if (k == 9) chk("wd_after_8th", {31'd0, stall_timeout}, 32'd1);
            cyc();
        end
        mem_stall = 1'b0;
        cyc();
        cyc();
        cyc();
        #3;
        chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("wd_reset", {31'd0, stall_timeout}, 32'd0);
        cyc();
        rst_n = 1'b1;

        // ---- Asynchronous reset mid-stall with a pending flush ----
        do_reset();
        start = 1'b1;
        cyc();
        cyc();
        for (int k = 1; k <= 3; k++) begin
            mem_stall    = 1'b1;
            branch_taken = (k == 2);
            if (k < 3) cyc();
        end
        #1;
        chk("pend_set", {31'd0, dut.pend_flush}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_pend", {31'd0, dut.pend_flush}, 32'd0);
        chk("arst_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        ctl_chk("arst_ctl", 5'b10100);
        cyc();
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk($sformatf("arst_noflush%0d", k), {31'd0, if_id_flush}, 32'd0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on simulated time
    initial begin
        #100000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
